// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI register controller: FSM states,
// command-byte field layout, status-byte layout and the PWM register map.
package spi_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_CMD     = 2'd0,
    ST_WDATA   = 2'd1,
    ST_RDATA   = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_ADDR_W   = 7;
  localparam int STAT_ERR_BIT = 7;

  localparam logic [CMD_ADDR_W-1:0] REG_DUTY   = 7'd0;
  localparam logic [CMD_ADDR_W-1:0] REG_PERIOD = 7'd1;
  localparam logic [CMD_ADDR_W-1:0] REG_CTRL   = 7'd2;

  function automatic logic [7:0] status_byte(input logic err);
    logic [7:0] b;
    b = 8'h00;
    b[STAT_ERR_BIT] = err;
    return b;
  endfunction

endpackage

// File: rtl/spi_reg_bank.sv
// NUM_REGS x 8 register file: one synchronous write port, one combinational
// read port (out-of-range reads return 0x00), async reset to RST_VAL.
module spi_reg_bank
  import spi_ctrl_pkg::*;
#(
  parameter int         NUM_REGS = 8,
  parameter logic [7:0] RST_VAL  = 8'h00
) (
  input  logic                    SCLK,
  input  logic                    rst,
  input  logic                    we,
  input  logic [CMD_ADDR_W-1:0]   waddr,
  input  logic [7:0]              wdata,
  input  logic [CMD_ADDR_W-1:0]   raddr,
  output logic [7:0]              rdata,
  output logic [8*NUM_REGS-1:0]   regs_flat
);

  logic [7:0] mem_q [NUM_REGS];
  logic [7:0] mem_d [NUM_REGS];

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      mem_d[i] = mem_q[i];
      if (we && (waddr == CMD_ADDR_W'(i))) begin
        mem_d[i] = wdata;
      end
    end
  end

  always_ff @(posedge SCLK or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= RST_VAL;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  always_comb begin
    rdata = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (raddr == CMD_ADDR_W'(i)) begin
        rdata = mem_q[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = mem_q[g];
  end

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI command/register controller: parses {R/W, addr} + data frames into the
// PWM register bank and sources MISO bytes. SPI_REG_CTRL_AUTOINC_EN enables bursts.
module spi_reg_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int         NUM_REGS = 8,
  parameter logic [7:0] RST_VAL  = 8'h00
) (
  input  logic                    SCLK,
  input  logic                    rst,
  input  logic                    ss,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_byte,
  output logic [7:0]              tx_byte,
  output logic [8*NUM_REGS-1:0]   regs_q,
  output logic                    wr_strobe,
  output logic [CMD_ADDR_W-1:0]   wr_addr,
  output logic                    err_addr
);

  localparam logic [7:0] NREGS8 = 8'(NUM_REGS);

  state_t                  state_q, state_d;
  logic [CMD_ADDR_W-1:0]   ptr_q, ptr_d;
  logic [7:0]              tx_q, tx_d;
  logic                    wr_strobe_q, wr_strobe_d;
  logic [CMD_ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic                    err_q, err_d;

  logic                    abort;
  logic                    rx_hit;
  logic [CMD_ADDR_W-1:0]   cmd_addr;
  logic                    cmd_rd;
  logic                    addr_ok;
  logic [CMD_ADDR_W-1:0]   ptr_inc;
  logic                    we;
  logic [CMD_ADDR_W-1:0]   rd_addr;
  logic [7:0]              rd_data;

  assign abort    = rst | ss;
  assign rx_hit   = rx_valid & ~ss;
  assign cmd_addr = rx_byte[CMD_ADDR_W-1:0];
  assign cmd_rd   = rx_byte[CMD_RW_BIT];
  assign addr_ok  = ({1'b0, cmd_addr} < NREGS8);
  assign ptr_inc  = ptr_q + 7'd1;

`ifdef SPI_REG_CTRL_AUTOINC_EN
  localparam logic [CMD_ADDR_W-1:0] LAST_PTR = CMD_ADDR_W'(NUM_REGS - 1);
  logic at_last;
  assign at_last = (ptr_q == LAST_PTR);
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    tx_d        = tx_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    err_d       = err_q;
    we          = 1'b0;
    rd_addr     = (state_q == ST_CMD) ? cmd_addr : ptr_inc;

    case (state_q)
      ST_CMD: begin
        if (rx_hit) begin
          if (!addr_ok) begin
            err_d   = 1'b1;
            tx_d    = 8'h00;
            state_d = ST_DISCARD;
          end else if (cmd_rd) begin
            ptr_d   = cmd_addr;
            tx_d    = rd_data;
            state_d = ST_RDATA;
          end else begin
            ptr_d   = cmd_addr;
            tx_d    = 8'h00;
            state_d = ST_WDATA;
          end
        end
      end
      ST_WDATA: begin
        if (rx_hit) begin
          we          = 1'b1;
          wr_strobe_d = 1'b1;
          wr_addr_d   = ptr_q;
`ifdef SPI_REG_CTRL_AUTOINC_EN
          if (at_last) state_d = ST_DISCARD;
          else         ptr_d   = ptr_inc;
`else
          state_d = ST_DISCARD;
`endif
        end
      end
      ST_RDATA: begin
        if (rx_hit) begin
`ifdef SPI_REG_CTRL_AUTOINC_EN
          if (at_last) begin
            state_d = ST_DISCARD;
            tx_d    = 8'h00;
          end else begin
            ptr_d = ptr_inc;
            tx_d  = rd_data;
          end
`else
          state_d = ST_DISCARD;
          tx_d    = 8'h00;
`endif
        end
      end
      default: begin
        tx_d = 8'h00;
      end
    endcase
  end

  // Frame state is cleared by either reset or slave deselect.
  always_ff @(posedge SCLK or posedge abort) begin
    if (abort) begin
      state_q <= ST_CMD;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge SCLK or posedge rst) begin
    if (rst) begin
      tx_q        <= 8'h00;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      tx_q        <= tx_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      err_q       <= err_d;
    end
  end

  spi_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .RST_VAL  (RST_VAL)
  ) u_bank (
    .SCLK      (SCLK),
    .rst       (rst),
    .we        (we),
    .waddr     (ptr_q),
    .wdata     (rx_byte),
    .raddr     (rd_addr),
    .rdata     (rd_data),
    .regs_flat (regs_q)
  );

  // Idle slot always shows status so a deselect updates MISO without a clock.
  assign tx_byte   = (state_q == ST_CMD) ? status_byte(err_q) : tx_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign err_addr  = err_q;

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Command/register controller sequencing the SPI slave byte stream into a PWM configuration register bank. Parses frames of one command byte (R/W + address) followed by data bytes, commits writes, and sources the byte the SPI slave shifts out on MISO. Sits between the SPI slave (byte side) and the PWM core (register side), entirely in the SCLK domain.

## Interface
- NUM_REGS, 8, number of 8-bit registers (2..128)
- RST_VAL, 0, reset value of every register byte
- SCLK  in  1  SPI clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high; clears registers, FSM, flags
- ss  in  1  slave select, active low; high asynchronously aborts the frame (FSM and pointer only, not registers)
- rx_valid  in  1  one-SCLK pulse: 8th bit of a byte captured
- rx_byte  in  8  received byte, valid with rx_valid
- tx_byte  out  8  byte to shift out for the next byte slot; reset 0x00
- regs_q  out  8*NUM_REGS  flat register contents, reg i at [8i+7:8i]; reset RST_VAL each
- wr_strobe  out  1  one-cycle pulse on register commit; reset 0
- wr_addr  out  7  address of last commit; reset 0
- err_addr  out  1  sticky: out-of-range address seen; reset 0, cleared by rst only

## Operation
- Command byte: bit7 = 1 read / 0 write; bits[6:0] = start address.
- States: CMD (reset/abort state), WDATA, RDATA, DISCARD.
- CMD, rx_valid: addr < NUM_REGS and write -> ptr<=addr, WDATA. Read -> ptr<=addr, tx_byte<=reg[addr], RDATA. addr >= NUM_REGS -> err_addr<=1, tx_byte<=0x00, DISCARD.
- CMD with no rx_valid: tx_byte = status byte {err_addr, 7'b0}.
- WDATA, rx_valid: reg[ptr]<=rx_byte, wr_strobe=1, wr_addr<=ptr; then per Configuration.
- RDATA, rx_valid: received byte ignored; advance per Configuration; tx_byte<=reg[ptr+1] or 0x00 when leaving to DISCARD.
- DISCARD: all rx_valid ignored, tx_byte=0x00, until ss high.
- ss high (any time): state<=CMD, ptr<=0, tx_byte<=status byte; a byte in flight is dropped, no partial commit.
- Pointer never wraps: after servicing address NUM_REGS-1 -> DISCARD.
- Read returns value as of the rx_valid edge that loads tx_byte; a write to the same address later in the frame does not alter the byte already loaded.

## Timing
- Write latency: rx_valid at edge k -> reg, wr_strobe, wr_addr updated at edge k; wr_strobe high exactly one SCLK period.
- Read: tx_byte updated at the edge carrying rx_valid; stable for the following 8 SCLK edges (SPI slave samples it bitwise).
- Back-to-back rx_valid every 8 edges supported without stall; no back-pressure.
- rst dominates ss; both asynchronous to SCLK, deasserted synchronously by system.

## Configuration
- SPI_REG_CTRL_AUTOINC_EN defined: burst mode; after each WDATA/RDATA byte ptr<=ptr+1, stay in state until ptr was NUM_REGS-1, then DISCARD.
- Undefined: single-access; after first data byte -> DISCARD (reads: second slot returns 0x00; extra write bytes dropped, no wr_strobe).

## Structure
- Package spi_ctrl_pkg: state enum, CMD_RW_BIT=7, CMD_ADDR_W=7, status-byte bit positions, PWM register map constants (REG_DUTY=0, REG_PERIOD=1, REG_CTRL=2).
- Sub-module spi_reg_bank: NUM_REGS x 8 register file, one write port (we/addr/data), one combinational read port, async reset to RST_VAL.

## Test plan
- Write frame 0x02,0x5A -> regs[2]=0x5A, one wr_strobe with wr_addr=2, others unchanged.
- Read frame 0x82,0x00 after above -> tx_byte=0x5A during second byte slot; no wr_strobe.
- AUTOINC_EN, NUM_REGS=8: 0x06,0x11,0x22,0x33 -> regs[6]=0x11, regs[7]=0x22, 0x33 dropped; two strobes. Without macro: only regs[6]=0x11.
- Command 0x0A (addr 10, NUM_REGS=8) then 0xFF -> err_addr=1, no writes, tx_byte=0x00; next frame's idle tx_byte=0x80.
- ss high after 4 bits of data byte, then new frame 0x01,0x77 -> no partial write, regs[1]=0x77.
- rst asserted mid-burst -> all regs RST_VAL, err_addr=0, wr_strobe=0, tx_byte=0x00 immediately.
